// File: rtl/procs_pkg.sv
// Shared types and constants for the processor phase sequencer.
package procs_pkg;

  localparam int unsigned NUM_PHASES_DEF = 5;
  localparam int unsigned PHASE_W        = 3;
  localparam int unsigned COUNT_W        = 32;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOP_PEND = 3'd3,
    ST_HALTED    = 3'd4
  } seq_state_e;

  localparam logic [PHASE_W-1:0] PHASE_RST = '0;
  localparam logic [COUNT_W-1:0] COUNT_RST = '0;

endpackage

// File: rtl/exec_debouncer.sv
// Synchronizes and debounces the raw exec button; pulses once per accepted press.
module exec_debouncer #(
  parameter int unsigned DEBOUNCE_LEN = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LEN);

  logic             sync_q1;
  logic             sync_q2;
  logic             prev_q;
  logic             primed;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_c;
  logic             stable_c;

  // Length of the current run of identical synchronized samples, saturating.
  always_comb begin
    cnt_c = CNT_W'(1);
    if (sync_q2 == prev_q) begin
      cnt_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    stable_c = (cnt_c == CNT_MAX);
  end

  // The first stable level after reset is adopted silently, so a button held
  // through reset must be released and pressed again to produce an event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      prev_q     <= 1'b0;
      primed     <= 1'b0;
      cnt_q      <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q1    <= raw_in;
      sync_q2    <= sync_q1;
      prev_q     <= sync_q2;
      cnt_q      <= cnt_c;
      rise_pulse <= 1'b0;
      if (stable_c) begin
        if (!primed) begin
          primed    <= 1'b1;
          level_out <= sync_q2;
        end else if (sync_q2 != level_out) begin
          level_out  <= sync_q2;
          rise_pulse <= sync_q2;
        end
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction timing generator with run/stop/single-step/halt control.
module phase_sequencer
  import procs_pkg::*;
#(
  parameter int unsigned NUM_PHASES      = NUM_PHASES_DEF,
  parameter int unsigned DEBOUNCE_LEN    = 16,
  parameter int unsigned RESET_PS_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step_mode,
  input  logic                  halt,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_bus,
  output logic                  reset_ps,
  output logic                  running,
  output logic                  halted,
  output logic [COUNT_W-1:0]    instr_count
);

  localparam int unsigned RST_W = (RESET_PS_CYCLES > 1) ? $clog2(RESET_PS_CYCLES) : 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_PS_CYCLES - 1);

  seq_state_e       state;
  logic [RST_W-1:0] rst_cnt;
  logic             one_shot;
  logic             exec_level;
  logic             exec_rise;
  logic             exec_ev;

  exec_debouncer #(
    .DEBOUNCE_LEN(DEBOUNCE_LEN)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (exec),
    .level_out (exec_level),
    .rise_pulse(exec_rise)
  );

  // A press event is only meaningful while the accepted level is high.
  assign exec_ev = exec_rise & exec_level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RESET;
      phase       <= PHASE_RST;
      phase_bus   <= '0;
      reset_ps    <= 1'b1;
      running     <= 1'b0;
      halted      <= 1'b0;
      instr_count <= COUNT_RST;
      one_shot    <= 1'b0;
      rst_cnt     <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state    <= ST_IDLE;
            reset_ps <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        ST_IDLE: begin
          if (exec_ev) begin
            state     <= ST_RUN;
            phase     <= PHASE_RST;
            phase_bus <= NUM_PHASES'(1);
            running   <= 1'b1;
            one_shot  <= step_mode;
          end
        end

        ST_RUN, ST_STOP_PEND: begin
          if (phase == LAST_PHASE) begin
            // Instruction boundary: the only place halt and stop take effect.
            instr_count <= instr_count + COUNT_W'(1);
            phase       <= PHASE_RST;
            if (halt) begin
              state     <= ST_HALTED;
              phase_bus <= '0;
              running   <= 1'b0;
              halted    <= 1'b1;
            end else if (one_shot || (state == ST_STOP_PEND) || exec_ev) begin
              state     <= ST_IDLE;
              phase_bus <= '0;
              running   <= 1'b0;
            end else begin
              phase_bus <= NUM_PHASES'(1);
            end
          end else begin
            phase     <= phase + PHASE_W'(1);
            phase_bus <= phase_bus << 1;
            if (exec_ev) begin
              state <= ST_STOP_PEND;
            end
          end
        end

        ST_HALTED: begin
          state <= ST_HALTED;
        end

        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed stimulus, per-cycle expectations.
module tb_phase_sequencer;

  typedef struct packed {
    logic [2:0]  ph;
    logic [4:0]  bus;
    logic        rps;
    logic        run;
    logic        hlt;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    int          tid;
    obs_t        val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec;
  logic        step_mode;
  logic        halt;
  logic [2:0]  phase;
  logic [4:0]  phase_bus;
  logic        reset_ps;
  logic        running;
  logic        halted;
  logic [31:0] instr_count;
  obs_t        act;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];

  phase_sequencer #(
    .NUM_PHASES(5),
    .DEBOUNCE_LEN(4),
    .RESET_PS_CYCLES(2)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .exec       (exec),
    .step_mode  (step_mode),
    .halt       (halt),
    .phase      (phase),
    .phase_bus  (phase_bus),
    .reset_ps   (reset_ps),
    .running    (running),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {phase, phase_bus, reset_ps, running, halted, instr_count};

  function automatic obs_t idle_o(input int unsigned c);
    return {3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'(c)};
  endfunction

  function automatic obs_t rst_o();
    return {3'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0};
  endfunction

  function automatic obs_t halt_o(input int unsigned c);
    return {3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'(c)};
  endfunction

  function automatic obs_t run_o(input int unsigned ph, input int unsigned c);
    logic [4:0] b;
    b = 5'd1 << ph;
    return {3'(ph), b, 1'b0, 1'b1, 1'b0, 32'(c)};
  endfunction

  task automatic report(input int tid, input int unsigned at, input obs_t got, input obs_t want);
    $display("FAIL t%0d cyc=%0d actual ph=%0d bus=%b rps=%b run=%b hlt=%b cnt=%0d expected ph=%0d bus=%b rps=%b run=%b hlt=%b cnt=%0d",
             tid, at, got.ph, got.bus, got.rps, got.run, got.hlt, got.cnt,
             want.ph, want.bus, want.rps, want.run, want.hlt, want.cnt);
  endtask

  task automatic push(input int unsigned c, input int tid, input obs_t v);
    exp_t e;
    e.cyc = c;
    e.tid = tid;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input int tid, input obs_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      report(tid, cyc, act, want);
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge with rst_n low; releases at the next negedge.
  task automatic release_reset(input int tid, output int unsigned u);
    push(cyc + 1, tid, rst_o());
    @(negedge clk);
    rst_n = 1'b1;
    u = cyc;
  endtask

  // Monitor: pops every expectation due this cycle and compares it.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || act !== e.val) begin
        n_bad++;
        report(e.tid, cyc, act, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned u, p, L, r, t, b;
    rst_n = 1'b0;
    exec = 1'b0;
    step_mode = 1'b0;
    halt = 1'b0;

    // Reset release with no exec: short reset_ps pulse, then idle.
    repeat (2) @(negedge clk);
    check_now(0, rst_o());
    release_reset(1, u);
    push(u + 1, 1, rst_o());
    for (int i = 2; i <= 20; i++) push(u + i, 1, idle_o(0));
    wait_until(u + 20);

    // Free run, then a stop request landing in phase 2.
    p = cyc;
    L = p + 7;
    for (int i = 1; i <= 6; i++) push(p + i, 2, idle_o(0));
    for (int i = 0; i < 20; i++) push(L + i, (i < 15) ? 2 : 3, run_o(i % 5, i / 5));
    for (int i = 20; i < 25; i++) push(L + i, 3, idle_o(4));
    exec = 1'b1;
    wait_until(p + 10);
    exec = 1'b0;
    wait_until(p + 18);
    exec = 1'b1;
    wait_until(p + 26);
    exec = 1'b0;
    wait_until(p + 34);

    // Single-step: three presses, three bursts; step_mode drops mid third burst.
    for (int k = 0; k < 3; k++) begin
      r = cyc;
      step_mode = 1'b1;
      for (int i = 1; i <= 6; i++) push(r + i, 4, idle_o(4 + k));
      for (int i = 0; i < 5; i++) push(r + 7 + i, 4, run_o(i, 4 + k));
      for (int i = 12; i <= 15; i++) push(r + i, 4, idle_o(5 + k));
      exec = 1'b1;
      wait_until(r + 8);
      exec = 1'b0;
      if (k == 2) begin
        wait_until(r + 9);
        step_mode = 1'b0;
      end
      wait_until(r + 16);
    end

    // Halt raised in phase 2 of the second instruction; later presses ignored.
    r = cyc;
    for (int i = 1; i <= 6; i++) push(r + i, 5, idle_o(7));
    for (int i = 0; i < 10; i++) push(r + 7 + i, 5, run_o(i % 5, 7 + i / 5));
    for (int i = 17; i <= 37; i++) push(r + i, 6, halt_o(9));
    exec = 1'b1;
    wait_until(r + 8);
    exec = 1'b0;
    wait_until(r + 14);
    halt = 1'b1;
    wait_until(r + 22);
    exec = 1'b1;
    wait_until(r + 30);
    exec = 1'b0;
    wait_until(r + 38);

    // Reset out of HALTED.
    halt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_now(7, rst_o());
    release_reset(7, u);
    push(u + 1, 7, rst_o());
    for (int i = 2; i <= 9; i++) push(u + i, 7, idle_o(0));
    wait_until(u + 9);

    // Bouncing exec: no event until it holds steady.
    t = cyc;
    b = t + 20;
    for (int unsigned c = t + 1; c <= b + 6; c++) push(c, 8, idle_o(0));
    for (int i = 0; i < 9; i++) push(b + 7 + i, 9, run_o(i % 5, i / 5));
    for (int i = 0; i < 10; i++) begin
      exec = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    exec = 1'b1;
    wait_until(b + 15);

    // Async reset mid phase 3 with exec still held through release.
    #2;
    rst_n = 1'b0;
    #1;
    check_now(10, rst_o());
    @(negedge clk);
    release_reset(11, u);
    push(u + 1, 11, rst_o());
    for (int i = 2; i <= 26; i++) push(u + i, 12, idle_o(0));
    for (int i = 0; i < 10; i++) push(u + 27 + i, 13, run_o(i % 5, i / 5));
    wait_until(u + 12);
    exec = 1'b0;
    wait_until(u + 20);
    exec = 1'b1;
    wait_until(u + 28);
    exec = 1'b0;
    wait_until(u + 38);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Generates the five-phase instruction timing that drives the processor datapath (fetch, register read, ALU, memory, write-back).
- Conditions the raw front-panel exec button into a clean start/stop event.
- Runs a run/stop/single-step/halt state machine.
- Emits registered, glitch-free phase strobes plus a datapath reset pulse.
- Sits directly upstream of the processor, which clocks its stage registers from phase_bus bits.

Parameters:
NUM_PHASES, 5, phases per instruction; phase_bus width and phase wrap point.
DEBOUNCE_LEN, 16, consecutive clocks synchronized exec must hold a new level before it is accepted.
RESET_PS_CYCLES, 2, clocks reset_ps stays high after reset release.

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
exec  input  1  raw exec button, active high, asynchronous to clock.
step_mode  input  1  level; 1 = each exec event runs exactly one instruction.
halt  input  1  level from processor; sampled only in the last-phase cycle.
phase  output  3  current phase index 0..NUM_PHASES-1; 0 when not running.
phase_bus  output  NUM_PHASES  one-hot phase strobe; all zero when not running.
reset_ps  output  1  active-high datapath reset pulse.
running  output  1  1 while in RUN or STOP_PEND.
halted  output  1  1 in HALTED.
instr_count  output  32  completed-instruction counter.

Behaviour:
- Reset (reset=0, async): state=RESET, phase=0, phase_bus=0, reset_ps=1, running=0, halted=0, instr_count=0; synchronizer and debounce cleared to 0.
- All outputs come straight from flops. No combinational logic on phase_bus.
- exec conditioning:
  - 2-flop synchronizer, then debounce counter. Accepted level changes after DEBOUNCE_LEN consecutive equal samples; any differing sample restarts the count.
  - A debounced 0->1 transition gives a one-clock exec_ev.
  - Debounced 1->0 gives no event.
  - A button held through reset release produces no event until it is released and pressed again.
- States: RESET, IDLE, RUN, STOP_PEND, HALTED.
- RESET: reset_ps=1 for RESET_PS_CYCLES clocks after reset deasserts, then IDLE with reset_ps=0. exec_ev is ignored.
- IDLE:
  - On exec_ev in cycle t: RUN, phase=0 and phase_bus=1 in cycle t+1.
  - A one-shot flag is latched from step_mode at this moment.
- RUN:
  - Each clock phase increments and phase_bus shifts left.
  - After phase NUM_PHASES-1, phase wraps to 0.
- In the last-phase cycle, priority is:
  - halt=1 -> HALTED.
  - else if one-shot or stop requested -> IDLE.
  - else continue at phase 0.
  - instr_count increments in every last-phase cycle, including when halting, and wraps 2^32-1 -> 0.
- exec_ev during RUN: STOP_PEND. The instruction completes normally, then IDLE with phase_bus=0 next cycle. A partial instruction never occurs.
- exec_ev during STOP_PEND, HALTED or RESET: ignored.
- HALTED: phase=0, phase_bus=0, halted=1. Left only via reset.
- step_mode changes while running affect only the next IDLE->RUN launch.
- halt is ignored outside the last-phase cycle.
- Mid-operation reset: immediate return to RESET state values. phase_bus drops asynchronously to 0; the downstream processor tolerates the truncated strobe.

Decomposition:
- Shared package (procs_pkg): state enum, NUM_PHASES default, phase index width constant, reset values.
- Sub-module exec_debouncer: synchronizer + debounce counter + rising-edge pulse. Parameter DEBOUNCE_LEN; ports clock, reset, raw_in, level_out, rise_pulse.
- Main FSM and phase counter stay in phase_sequencer.

Test Plan:
- Reset release, DEBOUNCE_LEN=4, RESET_PS_CYCLES=2, no exec -> reset_ps high exactly 2 clocks; phase_bus=00000 forever; instr_count=0.
- Clean exec press held 10 clocks, step_mode=0 -> phase_bus 00001 one clock after exec_ev, then 00010, 00100, 01000, 10000, 00001...; running=1; instr_count +1 per 5 clocks.
- Second press while running, pressed at phase 2 -> phases 3, 4 complete; then phase_bus=00000, running=0; instr_count exactly one higher than before the press.
- step_mode=1, three separate presses -> exactly 3 five-phase bursts, instr_count=3, IDLE between bursts.
- halt=1 asserted at phase 2, held -> instruction finishes; halted=1, phase_bus=0, instr_count incremented once; later exec presses ignored until reset.
- exec bounces 0/1 every 2 clocks for 20 clocks, then stays 1 -> no event during bouncing; exactly one run start 4+2 clocks after stable.
- Async reset asserted mid-phase 3 -> phase_bus=0 immediately; reset_ps=1; instr_count=0.
